// File: rtl/render_pkg.sv
// Shared types for the render frame scheduler: triangle payload, sequencer states, saturating counter helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package render_pkg;

    localparam int RENDER_TRI_W = 160;

    typedef logic [RENDER_TRI_W-1:0] triangle_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_RENDER,
        S_COOLDOWN,
        S_WAIT_VSYNC
    } sched_state_t;

    // Statistics counters stick at all-ones rather than wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/render_frame_scheduler_frame_watchdog.sv
// Render watchdog: counts enabled cycles and pulses expire on the TIMEOUT_CYC-th one.
// Latency: expire is combinational off the count register (asserted during the final counted cycle).
// Backpressure: none; load restarts the count from zero.
// Ports: clk/rst (sync, active-high), load (clear count), en (count this cycle), expire (pulse out).
module frame_watchdog #(
    parameter int TIMEOUT_CYC = 2**24
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        expire  = en && (count_q == CW'(TIMEOUT_CYC - 1));
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en && !expire) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/render_frame_scheduler.sv
// Per-frame sequencer: streams triangles to the renderer, kicks and watchdogs the render, flips buffers on vsync.
// Latency: accepted beat -> r_triangle 1 cycle; last beat -> r_active 2 cycles; r_done -> r_active low 1 cycle.
// Backpressure: tri_in_ready (registered) is high only while loading; beats beyond the cap are consumed and counted.
// Ports: tri_in/_valid/_last/_ready from game logic; r_triangle/_valid/r_active/r_done to renderer;
//        vsync from display; back_buf/front_buf, frame_count, dropped_count, timeout_err status.
module render_frame_scheduler
    import render_pkg::*;
#(
    parameter int MAX_TRIANGLES = 256,
    parameter int COOLDOWN_CYC  = 4,
    parameter int TIMEOUT_CYC   = 2**24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RENDER_TRI_W-1:0] tri_in,
    input  logic                    tri_in_valid,
    input  logic                    tri_in_last,
    output logic                    tri_in_ready,
    output logic [RENDER_TRI_W-1:0] r_triangle,
    output logic                    r_triangle_valid,
    output logic                    r_active,
    input  logic                    r_done,
    input  logic                    vsync,
    output logic                    back_buf,
    output logic                    front_buf,
    output logic [15:0]             frame_count,
    output logic [15:0]             dropped_count,
    output logic                    timeout_err
);
    localparam int LCW = $clog2(MAX_TRIANGLES);
    localparam int CCW = $clog2(COOLDOWN_CYC + 1);

    sched_state_t   state_q, state_d;
    logic           tri_in_ready_q, tri_in_ready_d;
    triangle_t      r_triangle_q, r_triangle_d;
    logic           r_triangle_valid_q, r_triangle_valid_d;
    logic           r_active_q, r_active_d;
    logic           back_buf_q, back_buf_d;
    logic           front_buf_q, front_buf_d;
    logic [15:0]    frame_count_q, frame_count_d;
    logic [15:0]    dropped_count_q, dropped_count_d;
    logic           timeout_err_q, timeout_err_d;
    logic           timed_out_q, timed_out_d;
    logic [LCW-1:0] load_cnt_q, load_cnt_d;
    logic [CCW-1:0] cool_cnt_q, cool_cnt_d;

    logic hs;
    logic wd_load;
    logic wd_en;
    logic wd_expire;

    frame_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .load   (wd_load),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d            = state_q;
        tri_in_ready_d     = 1'b0;
        r_triangle_d       = r_triangle_q;
        r_triangle_valid_d = 1'b0;
        r_active_d         = r_active_q;
        back_buf_d         = back_buf_q;
        front_buf_d        = front_buf_q;
        frame_count_d      = frame_count_q;
        dropped_count_d    = dropped_count_q;
        timeout_err_d      = timeout_err_q;
        timed_out_d        = timed_out_q;
        load_cnt_d         = load_cnt_q;
        cool_cnt_d         = cool_cnt_q;
        hs                 = tri_in_valid && tri_in_ready_q;
        wd_load            = 1'b0;
        wd_en              = (state_q == S_RENDER);

        case (state_q)
            // Idle and load share one path: the first accepted beat is an ordinary load beat.
            S_IDLE, S_LOAD: begin
                tri_in_ready_d = 1'b1;
                if (hs) begin
                    // Renderer's 8-bit triangle address must not wrap, so the cap is one below depth.
                    if (load_cnt_q < LCW'(MAX_TRIANGLES - 1)) begin
                        r_triangle_d       = tri_in;
                        r_triangle_valid_d = 1'b1;
                        load_cnt_d         = load_cnt_q + LCW'(1);
                    end else begin
                        dropped_count_d = sat_inc16(dropped_count_q);
                    end
                    if (tri_in_last) begin
                        state_d        = S_KICK;
                        tri_in_ready_d = 1'b0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            // One spare cycle so the final triangle lands before active rises.
            S_KICK: begin
                r_active_d = 1'b1;
                wd_load    = 1'b1;
                state_d    = S_RENDER;
            end
            S_RENDER: begin
                if (r_done) begin
                    r_active_d  = 1'b0;
                    timed_out_d = 1'b0;
                    cool_cnt_d  = '0;
                    state_d     = S_COOLDOWN;
                end else if (wd_expire) begin
                    r_active_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    timed_out_d   = 1'b1;
                    cool_cnt_d    = '0;
                    state_d       = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (cool_cnt_q == CCW'(COOLDOWN_CYC - 1)) begin
                    // A timed-out frame is abandoned: no flip, straight back to loading.
                    state_d = timed_out_q ? S_IDLE : S_WAIT_VSYNC;
                end else begin
                    cool_cnt_d = cool_cnt_q + CCW'(1);
                end
            end
            S_WAIT_VSYNC: begin
                if (vsync) begin
                    back_buf_d    = !back_buf_q;
                    front_buf_d   = back_buf_q;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
            load_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= S_IDLE;
            tri_in_ready_q     <= 1'b0;
            r_triangle_q       <= '0;
            r_triangle_valid_q <= 1'b0;
            r_active_q         <= 1'b0;
            back_buf_q         <= 1'b0;
            front_buf_q        <= 1'b1;
            frame_count_q      <= '0;
            dropped_count_q    <= '0;
            timeout_err_q      <= 1'b0;
            timed_out_q        <= 1'b0;
            load_cnt_q         <= '0;
            cool_cnt_q         <= '0;
        end else begin
            state_q            <= state_d;
            tri_in_ready_q     <= tri_in_ready_d;
            r_triangle_q       <= r_triangle_d;
            r_triangle_valid_q <= r_triangle_valid_d;
            r_active_q         <= r_active_d;
            back_buf_q         <= back_buf_d;
            front_buf_q        <= front_buf_d;
            frame_count_q      <= frame_count_d;
            dropped_count_q    <= dropped_count_d;
            timeout_err_q      <= timeout_err_d;
            timed_out_q        <= timed_out_d;
            load_cnt_q         <= load_cnt_d;
            cool_cnt_q         <= cool_cnt_d;
        end
    end

    assign tri_in_ready     = tri_in_ready_q;
    assign r_triangle       = r_triangle_q;
    assign r_triangle_valid = r_triangle_valid_q;
    assign r_active         = r_active_q;
    assign back_buf         = back_buf_q;
    assign front_buf        = front_buf_q;
    assign frame_count      = frame_count_q;
    assign dropped_count    = dropped_count_q;
    assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Directed bench for render_frame_scheduler: frame table plus reset sequences.
// Latency: n/a.
// Backpressure: source holds beats until tri_in_ready.
module tb_render_frame_scheduler;
    import render_pkg::*;

    localparam int MAXT = 256;
    localparam int CD   = 4;
    localparam int TO   = 100;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [RENDER_TRI_W-1:0] tri_in;
    logic                    tri_in_valid;
    logic                    tri_in_last;
    logic                    tri_in_ready;
    logic [RENDER_TRI_W-1:0] r_triangle;
    logic                    r_triangle_valid;
    logic                    r_active;
    logic                    r_done;
    logic                    vsync;
    logic                    back_buf;
    logic                    front_buf;
    logic [15:0]             frame_count;
    logic [15:0]             dropped_count;
    logic                    timeout_err;

    always #5 clk = ~clk;

    render_frame_scheduler #(
        .MAX_TRIANGLES (MAXT),
        .COOLDOWN_CYC  (CD),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_in           (tri_in),
        .tri_in_valid     (tri_in_valid),
        .tri_in_last      (tri_in_last),
        .tri_in_ready     (tri_in_ready),
        .r_triangle       (r_triangle),
        .r_triangle_valid (r_triangle_valid),
        .r_active         (r_active),
        .r_done           (r_done),
        .vsync            (vsync),
        .back_buf         (back_buf),
        .front_buf        (front_buf),
        .frame_count      (frame_count),
        .dropped_count    (dropped_count),
        .timeout_err      (timeout_err)
    );

    typedef struct {
        int   n;
        int   done_dly;   // 0 means never assert r_done
        int   exp_fwd;
        int   exp_drop;
        int   exp_frames;
        logic exp_back;
        logic exp_err;
    } frame_vec_t;

    int checks   = 0;
    int failures = 0;
    int fwd_seen = 0;
    logic [RENDER_TRI_W-1:0] exp_q[$];
    logic [RENDER_TRI_W-1:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RENDER_TRI_W-1:0] make_tri(input logic [15:0] id, input logic [15:0] idx);
        return {8'hA5, id[7:0], idx, {4{idx ^ 16'h5A5A, id}}};
    endfunction

    // Every forwarded triangle must match the next expected payload, in order.
    always @(negedge clk) begin
        if (!rst && r_triangle_valid) begin
            fwd_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL payload_unexpected actual=%0h required=none", r_triangle);
            end else begin
                mon_exp = exp_q.pop_front();
                if (r_triangle !== mon_exp) begin
                    failures++;
                    $display("FAIL payload actual=%0h required=%0h", r_triangle, mon_exp);
                end
            end
        end
    end

    task automatic wait_ready;
        int t;
        t = 0;
        while (!tri_in_ready && t < 20) begin
            tick;
            t++;
        end
        chk("ready_before_load", tri_in_ready, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"},    tri_in_ready, 0);
        chk({tag, "_rvalid"},   r_triangle_valid, 0);
        chk({tag, "_ractive"},  r_active, 0);
        chk({tag, "_back"},     back_buf, 0);
        chk({tag, "_front"},    front_buf, 1);
        chk({tag, "_frames"},   frame_count, 0);
        chk({tag, "_dropped"},  dropped_count, 0);
        chk({tag, "_err"},      timeout_err, 0);
        chk({tag, "_rtri_lo"},  r_triangle[31:0], 0);
        chk({tag, "_rtri_hi"},  r_triangle[159:128], 0);
    endtask

    task automatic run_frame(input int id, input frame_vec_t v);
        int t;
        int stalls;
        int low;
        fwd_seen = 0;
        wait_ready();
        stalls = 0;
        for (int i = 0; i < v.n; i++) begin
            tri_in       = make_tri(16'(id), 16'(i));
            tri_in_valid = 1'b1;
            tri_in_last  = (i == v.n - 1);
            if (i < MAXT - 1) exp_q.push_back(tri_in);
            t = 0;
            while (!tri_in_ready && t < 20) begin
                tick;
                t++;
                stalls++;
            end
            tick;
        end
        tri_in_valid = 1'b0;
        tri_in_last  = 1'b0;
        chk("load_stalls", stalls, 0);
        chk("ready_after_last", tri_in_ready, 0);
        chk("r_active_after_last_1", r_active, 0);
        tick;
        chk("r_active_after_last_2", r_active, 1);
        // vsync while rendering must not flip anything
        vsync = 1'b1;
        tick;
        vsync = 1'b0;
        chk("early_vsync_back", back_buf, v.exp_back ^ (v.done_dly > 0));
        if (v.done_dly > 0) begin
            repeat (v.done_dly) tick;
            chk("r_active_hold", r_active, 1);
            r_done = 1'b1;
            tick;
            r_done = 1'b0;
            chk("r_active_after_done", r_active, 0);
            low = 0;
            for (int k = 0; k < CD; k++) begin
                if (!tri_in_ready) low++;
                tick;
            end
            chk("ready_low_cooldown", low, CD);
            repeat (10) tick;
            chk("back_before_vsync", back_buf, !v.exp_back);
            chk("front_before_vsync", front_buf, v.exp_back);
            chk("frames_before_vsync", frame_count, v.exp_frames - 1);
            vsync = 1'b1;
            tick;
            vsync = 1'b0;
            chk("back_after_vsync", back_buf, v.exp_back);
            chk("front_after_vsync", front_buf, !v.exp_back);
        end else begin
            t = 1;
            while (!timeout_err && t < TO + 20) begin
                tick;
                t++;
            end
            chk("timeout_cycles", t, TO);
            chk("r_active_after_timeout", r_active, 0);
            repeat (CD + 2) tick;
            chk("back_no_flip", back_buf, v.exp_back);
            chk("front_no_flip", front_buf, !v.exp_back);
        end
        chk("frame_count", frame_count, v.exp_frames);
        chk("fwd_count", fwd_seen, v.exp_fwd);
        chk("dropped_count", dropped_count, v.exp_drop);
        chk("timeout_err", timeout_err, v.exp_err);
        chk("exp_queue_drained", exp_q.size(), 0);
    endtask

    frame_vec_t vecs[4];
    frame_vec_t post_rst;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        //           n    done fwd  drop frames back  err
        vecs[0] = '{3,    5,   3,   0,   1,     1'b1, 1'b0};
        vecs[1] = '{300,  3,   255, 45,  2,     1'b0, 1'b0};
        vecs[2] = '{1,    0,   1,   45,  2,     1'b0, 1'b1};
        vecs[3] = '{2,    7,   2,   45,  3,     1'b1, 1'b1};
        post_rst = '{1,   2,   1,   0,   1,     1'b1, 1'b0};

        rst          = 1'b1;
        tri_in       = '0;
        tri_in_valid = 1'b0;
        tri_in_last  = 1'b0;
        r_done       = 1'b0;
        vsync        = 1'b0;
        repeat (3) tick;
        check_reset_vals("reset");
        rst = 1'b0;
        tick;
        chk("ready_after_idle_entry", tri_in_ready, 1);

        for (int f = 0; f < 4; f++) begin
            run_frame(f + 1, vecs[f]);
        end

        // Reset in the middle of a render drops active on the next cycle and restores everything.
        wait_ready();
        for (int i = 0; i < 2; i++) begin
            tri_in       = make_tri(16'd8, 16'(i));
            tri_in_valid = 1'b1;
            tri_in_last  = (i == 1);
            exp_q.push_back(tri_in);
            tick;
        end
        tri_in_valid = 1'b0;
        tri_in_last  = 1'b0;
        tick;
        chk("midrender_active", r_active, 1);
        tick;
        rst = 1'b1;
        tick;
        check_reset_vals("midrender_rst");
        rst = 1'b0;
        exp_q.delete();
        run_frame(9, post_rst);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
